// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data memory with valid/ready response and saturating access counters
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_write,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [32:0] DEPTH_U = 33'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic err_q, write_q;
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;
  logic accept, done, legal;
  logic [IW-1:0] idx;
  assign accept = state_q == IDLE && req_valid;
  assign done = state_q == WAIT && cnt_q == 4'd0;
  assign legal = 33'(addr_q) < DEPTH_U;
  assign idx = addr_q[IW-1:0];
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  assign resp_write = write_q;
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
  // next state and latency countdown
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (accept) begin
      state_d = WAIT;
      cnt_d = 4'(LATENCY - 1);
    end else if (state_q == WAIT) begin
      state_d = done ? RESP : WAIT;
      cnt_d = done ? cnt_q : cnt_q - 4'd1;
    end else if (state_q == RESP && resp_ready) begin
      state_d = IDLE;
    end
  end
  // FSM register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // request latch, response registers and saturating counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      write_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (accept) begin
        wr_q <= req_write;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
      if (done) begin
        rdata_q <= (!wr_q && legal) ? mem_q[idx] : '0;
        err_q <= !legal;
        write_q <= wr_q;
        if (legal && !wr_q && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
        if (legal && wr_q && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end
  // storage array, written only when a legal write completes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (done && legal && wr_q) begin
      mem_q[idx] <= wdata_q;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks against a behavioural memory model
module tb_data_mem_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [7:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err, resp_write;
  logic [31:0] resp_rdata;
  logic [1:0] rd_count, wr_count;
  logic l_req_valid = 1'b0, l_req_write = 1'b0, l_resp_ready = 1'b0;
  logic [7:0] l_req_addr = '0;
  logic [31:0] l_req_wdata = '0;
  logic l_req_ready, l_resp_valid, l_resp_err, l_resp_write;
  logic [31:0] l_resp_rdata;
  logic [15:0] l_rd_count, l_wr_count;
  int vectors = 0, miscompares = 0;
  logic [31:0] mdl [16];
  int mrd, mwr;

  always #5 clock = ~clock;

  data_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .LATENCY(3), .CNT_W(2)) u0 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_write(resp_write), .rd_count(rd_count), .wr_count(wr_count));

  data_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .LATENCY(1), .CNT_W(16)) u1 (
    .clock(clock), .reset(reset), .req_valid(l_req_valid), .req_ready(l_req_ready),
    .req_write(l_req_write), .req_addr(l_req_addr), .req_wdata(l_req_wdata),
    .resp_valid(l_resp_valid), .resp_ready(l_resp_ready), .resp_rdata(l_resp_rdata),
    .resp_err(l_resp_err), .resp_write(l_resp_write), .rd_count(l_rd_count), .wr_count(l_wr_count));

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    mrd = 0;
    mwr = 0;
  endtask

  // expected outcome of one access, derived from the addressing and saturation rules
  task automatic model_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                              output logic [31:0] er, output logic ee);
    ee = a >= 8'd16;
    er = (!w && !ee) ? mdl[a[3:0]] : 32'h0;
    if (!ee && w) begin
      mdl[a[3:0]] = d;
      if (mwr < 3) mwr++;
    end
    if (!ee && !w && mrd < 3) mrd++;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    clear_model();
  endtask

  // one full request/response on u0; lat counts edges from accept to resp_valid, -1 on timeout
  task automatic do_txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic wo, output int lat);
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!resp_valid) lat = -1;
    rd = resp_rdata; er = resp_err; wo = resp_write;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #3;
    vectors++;
    if ({resp_valid, resp_err, resp_write, resp_rdata, rd_count, wr_count} !== 39'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%b e=%b w=%b rd=%h rc=%0d wc=%0d exp all zero",
               resp_valid, resp_err, resp_write, resp_rdata, rd_count, wr_count);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    clear_model();
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er, wo; int lat;
    do_txn(1'b1, 8'h05, 32'hDEADBEEF, rd, er, wo, lat);
    vectors++;
    if ({rd, er, wo} !== {32'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL wr_resp got rd=%h e=%b w=%b exp rd=0 e=0 w=1", rd, er, wo);
    end
    do_txn(1'b0, 8'h05, 32'h0, rd, er, wo, lat);
    vectors++;
    if ({rd, er, wo} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rd_after_wr got rd=%h e=%b w=%b exp rd=deadbeef e=0 w=0", rd, er, wo);
    end
    vectors++;
    if ({wr_count, rd_count} !== 4'b0101) begin
      miscompares++;
      $display("FAIL wr_rd_counts got wc=%0d rc=%0d exp 1 1", wr_count, rd_count);
    end
    mdl[5] = 32'hDEADBEEF; mwr = 1; mrd = 1;
  endtask

  task automatic test_latency();
    logic [2:0] seen;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05;
    @(posedge clock); #1;
    req_valid = 1'b0;
    seen[0] = resp_valid;
    @(posedge clock); #1; seen[1] = resp_valid;
    @(posedge clock); #1; seen[2] = resp_valid;
    vectors++;
    if (seen !== 3'b000) begin
      miscompares++;
      $display("FAIL lat3_early got valid N..N+2=%b exp 000", seen);
    end
    @(posedge clock); #1;
    vectors++;
    if (resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL lat3_valid got %b exp 1 after edge N+3", resp_valid);
    end
    if (mrd < 3) mrd++;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    l_req_valid = 1'b1; l_req_write = 1'b0; l_req_addr = 8'($urandom_range(0, 255));
    @(posedge clock); #1;
    l_req_valid = 1'b0;
    seen[0] = l_resp_valid;
    @(posedge clock); #1;
    vectors++;
    if ({seen[0], l_resp_valid, l_resp_rdata, l_rd_count} !== {1'b0, 1'b1, 32'h0, 16'd1}) begin
      miscompares++;
      $display("FAIL lat1 got early=%b valid=%b rd=%h rc=%0d exp 0 1 0 1",
               seen[0], l_resp_valid, l_resp_rdata, l_rd_count);
    end
    l_resp_ready = 1'b1;
    @(posedge clock); #1;
    l_resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, exp7; logic er, wo; int lat;
    exp7 = mdl[7];
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h07; req_wdata = 32'h12345678;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    if (mrd < 3) mrd++;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({resp_valid, req_ready, resp_err, resp_write, resp_rdata} !== {4'b1000, mdl[5]}) begin
        miscompares++;
        $display("FAIL hold_cycle%0d got v=%b rdy=%b e=%b w=%b rd=%h exp 1 0 0 0 %h",
                 i, resp_valid, req_ready, resp_err, resp_write, resp_rdata, mdl[5]);
      end
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    vectors++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL release got rdy=%b v=%b exp 1 0", req_ready, resp_valid);
    end
    do_txn(1'b0, 8'h07, 32'h0, rd, er, wo, lat);
    if (mrd < 3) mrd++;
    vectors++;
    if ({rd, wr_count} !== {exp7, 2'(mwr)}) begin
      miscompares++;
      $display("FAIL busy_ignored got rd7=%h wc=%0d exp %h %0d", rd, wr_count, exp7, mwr);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er, wo; int lat;
    logic [1:0] rc0, wc0;
    rc0 = rd_count; wc0 = wr_count;
    do_txn(1'b1, 8'd20, 32'h1234, rd, er, wo, lat);
    vectors++;
    if ({rd, er, wo, rd_count, wr_count} !== {32'h0, 2'b11, rc0, wc0}) begin
      miscompares++;
      $display("FAIL oor_write got rd=%h e=%b w=%b rc=%0d wc=%0d exp 0 1 1 %0d %0d",
               rd, er, wo, rd_count, wr_count, rc0, wc0);
    end
    do_txn(1'b0, 8'd4, 32'h0, rd, er, wo, lat);
    if (mrd < 3) mrd++;
    vectors++;
    if ({rd, er} !== {mdl[4], 1'b0}) begin
      miscompares++;
      $display("FAIL no_alias got rd=%h e=%b exp %h 0", rd, er, mdl[4]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, wo; int lat;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h03; req_wdata = 32'hAAAA5555;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    vectors++;
    if ({resp_valid, resp_err, resp_write, resp_rdata, rd_count, wr_count} !== 39'h0) begin
      miscompares++;
      $display("FAIL reset_async got v=%b e=%b w=%b rd=%h rc=%0d wc=%0d exp all zero",
               resp_valid, resp_err, resp_write, resp_rdata, rd_count, wr_count);
    end
    @(posedge clock); @(posedge clock); #1;
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold got v=%b exp 0", resp_valid);
    end
    reset = 1'b0;
    clear_model();
    do_txn(1'b0, 8'h03, 32'h0, rd, er, wo, lat);
    mrd = 1;
    vectors++;
    if ({rd, er} !== 33'h0) begin
      miscompares++;
      $display("FAIL discarded_write got rd=%h e=%b exp 0 0", rd, er);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] rd; logic er, wo; int lat;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_txn(1'b0, 8'($urandom_range(0, 15)), 32'h0, rd, er, wo, lat);
      vectors++;
      if (rd_count !== 2'(i + 1 > 3 ? 3 : i + 1)) begin
        miscompares++;
        $display("FAIL sat_read%0d got %0d exp %0d", i, rd_count, i + 1 > 3 ? 3 : i + 1);
      end
    end
    mrd = 3;
  endtask

  task automatic test_random();
    logic [31:0] rd, d, er_d; logic er, wo, w, ee; logic [7:0] a; int lat;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 23));
      d = $urandom;
      do_txn(w, a, d, rd, er, wo, lat);
      model_access(w, a, d, er_d, ee);
      vectors++;
      if ({rd, er, wo, rd_count, wr_count} !== {er_d, ee, w, 2'(mrd), 2'(mwr)} || lat != 3) begin
        miscompares++;
        $display("FAIL rand%0d w=%b a=%0d got rd=%h e=%b w=%b rc=%0d wc=%0d lat=%0d exp %h %b %b %0d %0d 3",
                 i, w, a, rd, er, wo, rd_count, wr_count, lat, er_d, ee, w, mrd, mwr);
      end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_write_read();
    test_latency();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the processor's data-memory access interface: accepts one read or write request at a time from the core and services it after a fixed programmable latency. It returns the result through a valid/ready response handshake. It sits between the memory stage and the data storage array, replacing the zero-wait combinational memory. It also keeps saturating read and write access counters for debug.

Parameters:
ADDR_W, 8, request address width (word address)
DATA_W, 32, data word width
DEPTH, 256, number of implemented words; legal addresses 0..DEPTH-1; DEPTH <= 2^ADDR_W
LATENCY, 2, edges from request accept to access completion; legal range 1..15
CNT_W, 16, width of each access counter

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
req_valid  input  1  core presents a request
req_ready  output  1  responder can accept a request (high only in IDLE)
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
resp_valid  output  1  response available
resp_ready  input  1  core takes the response
resp_rdata  output  DATA_W  read data; 0 for writes and errors
resp_err  output  1  address was out of range
resp_write  output  1  echo of the request type
rd_count  output  CNT_W  completed legal reads, saturating
wr_count  output  CNT_W  completed legal writes, saturating

Behaviour:
- Reset (async, active-high): state=IDLE; resp_valid=0; resp_rdata=0; resp_err=0; resp_write=0; rd_count=0; wr_count=0; latched request cleared; all DEPTH words cleared to 0. req_ready=1 as soon as reset deasserts.
- FSM has three states: IDLE, WAIT and RESP. req_ready=(state==IDLE). resp_valid=(state==RESP).
- IDLE: at posedge with req_valid=1, latch req_write, req_addr and req_wdata. Load cnt=LATENCY-1 and go to WAIT. With req_valid=0, stay in IDLE.
- WAIT: if cnt!=0, decrement cnt each edge. At the edge where cnt==0, perform the access and go to RESP.
  - Legal write: mem[addr] <= wdata; wr_count increments.
  - Legal read: resp_rdata <= mem[addr]; rd_count increments.
  - Illegal address (addr >= DEPTH): no storage change, no counter change; resp_err=1 and resp_rdata=0.
  - resp_write <= latched req_write. For writes, resp_rdata=0.
- Latency: request accepted at edge N gives resp_valid=1 in the cycle after edge N+LATENCY.
- RESP: resp_* outputs are held stable while resp_ready=0, with unlimited backpressure. At the edge with resp_ready=1, go to IDLE and clear resp_valid. resp_rdata, resp_err and resp_write hold their values until the next completion.
- No overlap: requests are ignored outside IDLE, because req_ready=0 there. Minimum spacing between accepts is LATENCY+2 cycles.
- Request inputs are sampled only at the accept edge. Changes to them during WAIT or RESP have no effect.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Read-after-write to the same address returns the newly written data.
- Reset asserted in WAIT: the pending access is discarded; a pending write is never applied. Reset asserted in RESP: the response is dropped.

Test Plan:
- Write then read: write 0xDEADBEEF to addr 0x05, then read addr 0x05. Required: read response has resp_rdata=0xDEADBEEF, resp_err=0, resp_write=0; wr_count=1, rd_count=1.
- Latency: with LATENCY=3, accept a read at edge N. Required: resp_valid=0 through edge N+2 and 1 after edge N+3. Repeat with LATENCY=1: resp_valid=1 after edge N+1.
- Backpressure and busy: hold resp_ready=0 for 10 cycles in RESP, and pulse req_valid with addr 0x07 during WAIT. Required: outputs stable for all 10 cycles; the second request is not accepted; addr 0x07 is untouched; after resp_ready=1, IDLE and req_ready=1 follow on the next cycle.
- Out of range: with DEPTH=16, write 0x1234 to addr 20, then read addr 4. Required: resp_err=1 and resp_rdata=0 on the write; no counter change; addr 4 still reads 0 (no aliasing).
- Reset mid-operation: write 0xAAAA5555 to addr 3 and assert reset during WAIT. Required: outputs clear immediately; a subsequent read of addr 3 returns 0 and resp_valid=0 during reset.
- Counter saturation: with CNT_W=2, perform 5 legal reads. Required: rd_count reads 1, 2, 3, 3, 3.
